// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: sits between the load/store stage and a single-word RAM port.
// Vector stores are split into LANES word writes and vector loads are gathered from
// LANES word reads. Scalar accesses take one beat. Requests that would run past the
// end of the RAM are answered with resp_err and never reach the memory.
module vec_mem_sequencer #(
   parameter int S    = 32,
   parameter int V    = 192,
   parameter int SIZE = 30015
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic         req_isVector,
   input  logic [S-1:0] req_addr,
   input  logic [V-1:0] req_wd,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [V-1:0] resp_rd,
   output logic         resp_err,
   output logic         mem_we,
   output logic [S-1:0] mem_addr,
   output logic [S-1:0] mem_wd,
   input  logic [S-1:0] mem_rd
);

   localparam int LANES = V / S;
   localparam int LW    = $clog2(LANES + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   logic [1:0]    state_q,    state_d;
   logic [LW-1:0] lane_q,     lane_d;
   logic [LW-1:0] last_q,     last_d;
   logic [V-1:0]  wd_q,       wd_d;
   logic [V-1:0]  resp_rd_q,  resp_rd_d;
   logic          resp_err_q, resp_err_d;
   logic          mem_we_q,   mem_we_d;
   logic [S-1:0]  mem_addr_q, mem_addr_d;
   logic [S-1:0]  mem_wd_q,   mem_wd_d;

   // One bit wider than the address so that addr+n cannot wrap past zero.
   logic [S:0]    req_n;
   logic [S:0]    req_end;
   logic          req_oob;

   // Bounds check of the incoming request: last word touched must be below SIZE.
   always_comb begin
      req_n   = req_isVector ? (S+1)'(LANES) : (S+1)'(1);
      req_end = {1'b0, req_addr} + req_n;
      req_oob = (req_end > (S+1)'(SIZE));
   end

   // Next-state and next-output logic for the beat sequencer.
   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      last_d     = last_q;
      wd_d       = wd_q;
      resp_rd_d  = resp_rd_q;
      resp_err_d = resp_err_q;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_wd_d   = mem_wd_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               lane_d     = '0;
               last_d     = req_isVector ? LW'(LANES - 1) : '0;
               resp_rd_d  = '0;
               resp_err_d = 1'b0;
               if (req_oob) begin
                  state_d    = ST_RESP;
                  resp_err_d = 1'b1;
               end else if (req_we) begin
                  // Beat 0 is launched straight from the request; the rest of the
                  // store data is kept pre-shifted so lane k is always at the bottom.
                  state_d    = ST_WRITE;
                  mem_we_d   = 1'b1;
                  mem_addr_d = req_addr;
                  mem_wd_d   = req_wd[S-1:0];
                  wd_d       = req_wd >> S;
               end else begin
                  state_d    = ST_READ;
                  mem_addr_d = req_addr;
               end
            end
         end

         ST_WRITE: begin
            if (lane_q == last_q) begin
               state_d = ST_RESP;
            end else begin
               mem_we_d   = 1'b1;
               mem_addr_d = mem_addr_q + S'(1);
               mem_wd_d   = wd_q[S-1:0];
               wd_d       = wd_q >> S;
               lane_d     = lane_q + LW'(1);
            end
         end

         ST_READ: begin
            // RAM answers combinationally for the address on mem_addr this cycle.
            for (int k = 0; k < LANES; k++) begin
               if (lane_q == LW'(k)) begin
                  resp_rd_d[k*S +: S] = mem_rd;
               end
            end
            if (lane_q == last_q) begin
               state_d = ST_RESP;
            end else begin
               mem_addr_d = mem_addr_q + S'(1);
               lane_d     = lane_q + LW'(1);
            end
         end

         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, lane counter and all externally visible registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         lane_q     <= '0;
         last_q     <= '0;
         resp_rd_q  <= '0;
         resp_err_q <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_wd_q   <= '0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         last_q     <= last_d;
         resp_rd_q  <= resp_rd_d;
         resp_err_q <= resp_err_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_wd_q   <= mem_wd_d;
      end
   end

   // Pending store lanes; only meaningful while a write burst is in flight.
   always_ff @(posedge clk) begin
      wd_q <= wd_d;
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rd    = resp_rd_q;
   assign resp_err   = resp_err_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Testbench for vec_mem_sequencer: RAM model, transaction-level reference model with a
// per-cycle compare process, and directed requests with hand-computed expectations.
module tb_vec_mem_sequencer;

   localparam int S     = 32;
   localparam int V     = 192;
   localparam int SIZE  = 30015;
   localparam int LANES = 6;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic         req_isVector;
   logic [S-1:0] req_addr;
   logic [V-1:0] req_wd;
   logic         resp_valid;
   logic         resp_ready;
   logic [V-1:0] resp_rd;
   logic         resp_err;
   logic         mem_we;
   logic [S-1:0] mem_addr;
   logic [S-1:0] mem_wd;
   logic [S-1:0] mem_rd;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   vec_mem_sequencer #(.S(S), .V(V), .SIZE(SIZE)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_isVector (req_isVector),
      .req_addr     (req_addr),
      .req_wd       (req_wd),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rd      (resp_rd),
      .resp_err     (resp_err),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wd       (mem_wd),
      .mem_rd       (mem_rd)
   );

   // RAM: combinational read, write on the rising edge.
   logic [S-1:0] ram [SIZE];
   int pulse_cnt = 0;
   assign mem_rd = (mem_addr < S'(SIZE)) ? ram[mem_addr] : '0;

   always @(posedge clk) begin
      if (mem_we) begin
         pulse_cnt++;
         if (mem_addr < S'(SIZE)) ram[mem_addr] = mem_wd;
      end
   end

   task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endtask

   // Reference model: each accepted request becomes a list of expected RAM beats
   // followed by one expected response that stays up until consumed.
   typedef struct {
      logic         we;
      logic [S-1:0] addr;
      logic [S-1:0] wd;
   } beat_t;

   beat_t        beats[$];
   bit           resp_pend = 1'b0;
   bit           armed     = 1'b0;
   logic [V-1:0] exp_rd;
   logic         exp_err;

   always @(posedge clk) begin
      if (!rst_n) begin
         beats.delete();
         resp_pend = 1'b0;
         armed     = 1'b1;
      end else if (armed) begin
         if (beats.size() > 0) begin
            void'(beats.pop_front());
         end else if (resp_pend) begin
            if (resp_ready) resp_pend = 1'b0;
         end else if (req_valid) begin
            int n;
            n         = req_isVector ? LANES : 1;
            exp_rd    = '0;
            exp_err   = 1'b0;
            resp_pend = 1'b1;
            if (longint'(req_addr) + longint'(n) > longint'(SIZE)) begin
               exp_err = 1'b1;
            end else begin
               for (int k = 0; k < n; k++) begin
                  beat_t b;
                  b.we   = req_we;
                  b.addr = req_addr + S'(k);
                  b.wd   = req_wd[k*S +: S];
                  beats.push_back(b);
                  if (!req_we) exp_rd[k*S +: S] = ram[req_addr + S'(k)];
               end
            end
         end
      end
   end

   // Per-cycle comparison of DUT outputs against the model, away from the active edge.
   always @(negedge clk) begin
      if (armed && rst_n) begin
         if (beats.size() > 0) begin
            chk("beat_we", V'(mem_we), V'(beats[0].we));
            chk("beat_addr", V'(mem_addr), V'(beats[0].addr));
            if (beats[0].we) chk("beat_wd", V'(mem_wd), V'(beats[0].wd));
            chk("beat_req_ready", V'(req_ready), V'(1'b0));
            chk("beat_resp_valid", V'(resp_valid), V'(1'b0));
         end else if (resp_pend) begin
            chk("resp_valid", V'(resp_valid), V'(1'b1));
            chk("resp_rd", resp_rd, exp_rd);
            chk("resp_err", V'(resp_err), V'(exp_err));
            chk("resp_req_ready", V'(req_ready), V'(1'b0));
            chk("resp_mem_we", V'(mem_we), V'(1'b0));
         end else begin
            chk("idle_req_ready", V'(req_ready), V'(1'b1));
            chk("idle_resp_valid", V'(resp_valid), V'(1'b0));
            chk("idle_mem_we", V'(mem_we), V'(1'b0));
         end
      end
   end

   // Issue one request, measure accept-to-response latency and write pulses, optionally
   // hold off the response for 'hold' cycles while a competing request is presented.
   task automatic run_req(input logic we, input logic vec, input logic [S-1:0] addr,
                          input logic [V-1:0] wd, input int hold,
                          output int lat, output int pulses,
                          output logic [V-1:0] rd, output logic err);
      int p0;
      int guard;
      lat = -1; pulses = -1; rd = '0; err = 1'b0;
      req_we = we; req_isVector = vec; req_addr = addr; req_wd = wd; req_valid = 1'b1;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!req_ready) begin
         tmo("accept");
         req_valid = 1'b0;
         return;
      end
      p0 = pulse_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!resp_valid) begin
         tmo("resp_valid");
         return;
      end
      pulses = pulse_cnt - p0;
      rd     = resp_rd;
      err    = resp_err;
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_we = 1'b0; req_isVector = 1'b0; req_addr = 32'd5;
         @(posedge clk); #1;
         chk("bp_resp_valid", V'(resp_valid), V'(1'b1));
         chk("bp_resp_rd", resp_rd, rd);
         chk("bp_req_ready", V'(req_ready), V'(1'b0));
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int           lat, pulses;
      logic [V-1:0] rd, wd;
      logic         err;
      logic [V-1:0] exp_vld;

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_isVector = 1'b0;
      req_addr = '0; req_wd = '0; resp_ready = 1'b0;
      for (int i = 0; i < SIZE; i++) ram[i] = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", V'(req_ready), V'(1'b1));
      chk("rst_resp_valid", V'(resp_valid), V'(1'b0));
      chk("rst_resp_err", V'(resp_err), V'(1'b0));
      chk("rst_resp_rd", resp_rd, '0);
      chk("rst_mem_we", V'(mem_we), V'(1'b0));
      chk("rst_mem_addr", V'(mem_addr), '0);
      chk("rst_mem_wd", V'(mem_wd), '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Vector store at 100, lanes 0x11..0x66.
      for (int k = 0; k < LANES; k++) wd[k*S +: S] = 32'h11 * (k + 1);
      run_req(1'b1, 1'b1, 32'd100, wd, 0, lat, pulses, rd, err);
      chk("vst_lat", V'(lat), V'(7));
      chk("vst_pulses", V'(pulses), V'(6));
      chk("vst_err", V'(err), V'(1'b0));
      chk("vst_rd", rd, '0);
      chk("vst_ram100", V'(ram[100]), V'(32'h11));
      chk("vst_ram102", V'(ram[102]), V'(32'h33));
      chk("vst_ram105", V'(ram[105]), V'(32'h66));

      // Vector load at 100 from 0xA0..0xA5.
      for (int k = 0; k < LANES; k++) ram[100 + k] = 32'hA0 + k;
      exp_vld = 192'h000000A5_000000A4_000000A3_000000A2_000000A1_000000A0;
      run_req(1'b0, 1'b1, 32'd100, '0, 0, lat, pulses, rd, err);
      chk("vld_lat", V'(lat), V'(7));
      chk("vld_pulses", V'(pulses), V'(0));
      chk("vld_rd", rd, exp_vld);

      // Scalar load at 30008 holding 1.
      ram[30008] = 32'h1;
      run_req(1'b0, 1'b0, 32'd30008, '0, 0, lat, pulses, rd, err);
      chk("sld_lat", V'(lat), V'(2));
      chk("sld_rd", rd, 192'h1);

      // Scalar store of 0xDEAD to 5.
      run_req(1'b1, 1'b0, 32'd5, 192'hFFFF_0000_DEAD, 0, lat, pulses, rd, err);
      chk("sst_lat", V'(lat), V'(2));
      chk("sst_pulses", V'(pulses), V'(1));
      chk("sst_ram5", V'(ram[5]), V'(32'hDEAD));
      chk("sst_ram6", V'(ram[6]), V'(32'h0));

      // Last legal vector: 30009..30014.
      for (int k = 0; k < LANES; k++) wd[k*S +: S] = 32'h1000 + k;
      run_req(1'b1, 1'b1, 32'd30009, wd, 0, lat, pulses, rd, err);
      chk("edge_err", V'(err), V'(1'b0));
      chk("edge_pulses", V'(pulses), V'(6));
      chk("edge_ram30009", V'(ram[30009]), V'(32'h1000));
      chk("edge_ram30014", V'(ram[30014]), V'(32'h1005));

      // One word past the end: rejected after one cycle, no writes.
      run_req(1'b1, 1'b1, 32'd30010, wd, 0, lat, pulses, rd, err);
      chk("oob_vec_err", V'(err), V'(1'b1));
      chk("oob_vec_lat", V'(lat), V'(1));
      chk("oob_vec_pulses", V'(pulses), V'(0));
      chk("oob_vec_rd", rd, '0);

      run_req(1'b0, 1'b0, 32'd30015, '0, 0, lat, pulses, rd, err);
      chk("oob_sc_err", V'(err), V'(1'b1));

      run_req(1'b1, 1'b0, 32'hFFFF_FFFF, wd, 0, lat, pulses, rd, err);
      chk("oob_wrap_err", V'(err), V'(1'b1));
      chk("oob_wrap_pulses", V'(pulses), V'(0));

      // Backpressure: response held 5 cycles while a scalar load of 5 waits.
      run_req(1'b0, 1'b1, 32'd100, '0, 5, lat, pulses, rd, err);
      chk("bp_rd", rd, exp_vld);
      run_req(1'b0, 1'b0, 32'd5, '0, 0, lat, pulses, rd, err);
      chk("bp_next_rd", rd, 192'hDEAD);
      chk("bp_next_lat", V'(lat), V'(2));

      // Reset asserted while the third beat of a store burst is on the port.
      for (int k = 0; k < LANES; k++) wd[k*S +: S] = 32'h7000 + k;
      req_we = 1'b1; req_isVector = 1'b1; req_addr = 32'd200; req_wd = wd; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_mid_beat_addr", V'(mem_addr), V'(32'd202));
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_mem_we", V'(mem_we), V'(1'b0));
      chk("rst_mid_resp_valid", V'(resp_valid), V'(1'b0));
      chk("rst_mid_req_ready", V'(req_ready), V'(1'b1));
      rst_n = 1'b1;
      chk("rst_mid_ram200", V'(ram[200]), V'(32'h7000));
      chk("rst_mid_ram202", V'(ram[202]), V'(32'h7002));
      chk("rst_mid_ram203", V'(ram[203]), V'(32'h0));
      chk("rst_mid_ram205", V'(ram[205]), V'(32'h0));

      run_req(1'b0, 1'b0, 32'd201, '0, 0, lat, pulses, rd, err);
      chk("rst_after_rd", rd, 192'h7001);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
